// File: rtl/pipeline_pkg.sv
// Shared types for the MIPS pipeline control path: sequencer states and the
// per-register stall/flush bundle consumed by the top-level datapath.
package pipeline_pkg;

  typedef enum logic [1:0] {
    INIT     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic if_id;
    logic id_ex;
    logic ex_mem;
    logic mem_wb;
  } stage_ctrl_t;

  typedef struct packed {
    stage_ctrl_t stall;
    stage_ctrl_t flush;
    logic        pc_write;
  } hazard_ctrl_t;

  // $zero is hardwired, so a load targeting it never creates a dependency.
  function automatic logic load_use_hit(
    input logic       mem_read,
    input logic [4:0] load_rt,
    input logic [4:0] src_rs,
    input logic [4:0] src_rt
  );
    return mem_read && (load_rt != REG_ZERO) &&
           ((load_rt == src_rs) || (load_rt == src_rt));
  endfunction

endpackage

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: hazard detection inputs, per-register control
// outputs and debug counters.
interface pipeline_hazard_controller_if #(
  parameter int COUNT_WIDTH = 16
);
  logic                   clearCounters;
  logic                   idExMemRead;
  logic [4:0]             idExRt;
  logic [4:0]             ifIdRs;
  logic [4:0]             ifIdRt;
  logic                   branchTaken;
  logic                   memRequest;
  logic                   memReady;

  logic                   pcWriteEnable;
  logic                   stallIfId;
  logic                   stallIdEx;
  logic                   stallExMem;
  logic                   stallMemWb;
  logic                   flushIfId;
  logic                   flushIdEx;
  logic                   flushExMem;
  logic                   flushMemWb;
  logic                   memError;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] stallCycleCount;
  logic [COUNT_WIDTH-1:0] flushCount;

  modport master (
    input  clearCounters, idExMemRead, idExRt, ifIdRs, ifIdRt,
           branchTaken, memRequest, memReady,
    output pcWriteEnable, stallIfId, stallIdEx, stallExMem, stallMemWb,
           flushIfId, flushIdEx, flushExMem, flushMemWb,
           memError, busy, stallCycleCount, flushCount
  );

  modport slave (
    output clearCounters, idExMemRead, idExRt, ifIdRs, ifIdRt,
           branchTaken, memRequest, memReady,
    input  pcWriteEnable, stallIfId, stallIdEx, stallExMem, stallMemWb,
           flushIfId, flushIdEx, flushExMem, flushMemWb,
           memError, busy, stallCycleCount, flushCount
  );
endinterface

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign count = count_reg;

endmodule

// File: rtl/pipeline_hazard_controller.sv
// Pipeline sequencer: post-reset flush, memory-wait stall with timeout,
// branch flush and load-use stall, plus saturating debug counters.
module pipeline_hazard_controller
  import pipeline_pkg::*;
#(
  parameter int INIT_CYCLES = 4,
  parameter int MEM_TIMEOUT = 16,
  parameter int COUNT_WIDTH = 16
) (
  input logic                          clk,
  input logic                          reset,
  pipeline_hazard_controller_if.master bus
);

  localparam logic [3:0] INIT_LAST   = 4'(INIT_CYCLES - 1);
  localparam logic [7:0] WAIT_LIMIT  = 8'(MEM_TIMEOUT);

  state_t       state_reg, state_next;
  logic [3:0]   init_count_reg, init_count_next;
  logic [7:0]   wait_count_reg, wait_count_next;
  logic         mem_error_reg, mem_error_next;

  hazard_ctrl_t ctrl;
  logic         load_use;
  logic         mem_hold;
  logic         branch_flush;

  assign load_use = load_use_hit(bus.idExMemRead, bus.idExRt, bus.ifIdRs, bus.ifIdRt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= INIT;
      init_count_reg <= 4'd0;
      wait_count_reg <= 8'd0;
      mem_error_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      init_count_reg <= init_count_next;
      wait_count_reg <= wait_count_next;
      mem_error_reg  <= mem_error_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    init_count_next = init_count_reg;
    wait_count_next = wait_count_reg;
    mem_error_next  = mem_error_reg;
    ctrl            = '0;
    mem_hold        = 1'b0;
    branch_flush    = 1'b0;

    unique case (state_reg)
      INIT: begin
        init_count_next = init_count_reg + 4'd1;
        if (init_count_reg == INIT_LAST) begin
          state_next      = RUN;
          init_count_next = 4'd0;
        end
      end
      RUN: begin
        if (bus.memRequest && !bus.memReady) begin
          mem_hold        = 1'b1;
          state_next      = MEM_WAIT;
          wait_count_next = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!bus.memReady) begin
          mem_hold        = 1'b1;
          wait_count_next = wait_count_reg + 8'd1;
          // Give up on the access; the error flag tells software it was lost.
          if (wait_count_reg == WAIT_LIMIT) begin
            mem_error_next  = 1'b1;
            state_next      = RUN;
            wait_count_next = 8'd0;
          end
        end else begin
          state_next      = RUN;
          wait_count_next = 8'd0;
        end
      end
      default: begin
        state_next      = INIT;
        init_count_next = 4'd0;
        wait_count_next = 8'd0;
      end
    endcase

    // Output priority: init flush, memory hold, branch, load-use, free run.
    if (state_reg == INIT || !(state_reg == RUN || state_reg == MEM_WAIT)) begin
      ctrl.flush = '1;
    end else if (mem_hold) begin
      ctrl.stall.if_id  = 1'b1;
      ctrl.stall.id_ex  = 1'b1;
      ctrl.stall.ex_mem = 1'b1;
      ctrl.flush.mem_wb = 1'b1;
    end else if (bus.branchTaken) begin
      ctrl.flush.if_id = 1'b1;
      ctrl.flush.id_ex = 1'b1;
      ctrl.pc_write    = 1'b1;
      branch_flush     = 1'b1;
    end else if (load_use) begin
      ctrl.stall.if_id = 1'b1;
      ctrl.flush.id_ex = 1'b1;
    end else begin
      ctrl.pc_write = 1'b1;
    end
  end

  assign bus.pcWriteEnable = ctrl.pc_write;
  assign bus.stallIfId     = ctrl.stall.if_id;
  assign bus.stallIdEx     = ctrl.stall.id_ex;
  assign bus.stallExMem    = ctrl.stall.ex_mem;
  assign bus.stallMemWb    = ctrl.stall.mem_wb;
  assign bus.flushIfId     = ctrl.flush.if_id;
  assign bus.flushIdEx     = ctrl.flush.id_ex;
  assign bus.flushExMem    = ctrl.flush.ex_mem;
  assign bus.flushMemWb    = ctrl.flush.mem_wb;
  assign bus.memError      = mem_error_reg;
  assign bus.busy          = (state_reg != RUN);

  // Counter 0: stalled cycles outside INIT; counter 1: taken-branch flushes.
  logic [1:0]             cnt_inc;
  logic [COUNT_WIDTH-1:0] cnt_val [2];

  assign cnt_inc[0] = (state_reg == RUN || state_reg == MEM_WAIT) && !ctrl.pc_write;
  assign cnt_inc[1] = branch_flush;

  for (genvar gi = 0; gi < 2; gi++) begin : g_counter
    sat_counter #(
      .WIDTH(COUNT_WIDTH)
    ) u_counter (
      .clk   (clk),
      .reset (reset),
      .inc   (cnt_inc[gi]),
      .clr   (bus.clearCounters),
      .count (cnt_val[gi])
    );
  end

  assign bus.stallCycleCount = cnt_val[0];
  assign bus.flushCount      = cnt_val[1];

endmodule
